// File: rtl/segmentation_pkg.sv
// Shared types and default geometry for the image segmentation / reassembly path.
package segmentation_pkg;

    localparam int DEF_DIM   = 8;
    localparam int DEF_WIDTH = 8;

    typedef logic [DEF_WIDTH-1:0] pixel_t;
    typedef pixel_t pixel_row_t [DEF_DIM];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } reasm_state_t;

    // Counter width that stays legal when a count range collapses to a single value.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/segmentation_reassembler_if.sv
// Row-stream input and word-memory write bus of the reassembler.
// REASM_CHECKSUM_EN adds the running frame checksum to the bus.
interface segmentation_reassembler_if #(
    parameter int DIM   = 8,
    parameter int WIDTH = 8,
    parameter int ADDR  = 13
);
    localparam int CKS_W = WIDTH + ADDR + $clog2(DIM);

    logic             enable;
    logic             valid_in;
    logic [WIDTH-1:0] din [DIM];
    logic             mem_we;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_din [DIM];
    logic             busy;
    logic             frame_done;
    logic             overrun;
`ifdef REASM_CHECKSUM_EN
    logic [CKS_W-1:0] checksum;

    modport master (output enable, valid_in, din,
                    input  mem_we, mem_addr, mem_din, busy, frame_done, overrun, checksum);
    modport slave  (input  enable, valid_in, din,
                    output mem_we, mem_addr, mem_din, busy, frame_done, overrun, checksum);
`else
    modport master (output enable, valid_in, din,
                    input  mem_we, mem_addr, mem_din, busy, frame_done, overrun);
    modport slave  (input  enable, valid_in, din,
                    output mem_we, mem_addr, mem_din, busy, frame_done, overrun);
`endif

endinterface

// File: rtl/segmentation_reassembler_addr_gen.sv
// Block-row position counters (row, bx, by) and the raster word address they map to.
module reassembler_addr_gen
    import segmentation_pkg::*;
#(
    parameter int DIM   = DEF_DIM,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_clr,
    input  logic                                 i_adv,
    output logic [$clog2((IMG_W/DIM)*IMG_H)-1:0] o_addr,
    output logic                                 o_last
);
    localparam int WPR  = IMG_W / DIM;
    localparam int BPC  = IMG_H / DIM;
    localparam int ADDR = $clog2(WPR * IMG_H);
    localparam int RW   = cnt_w(DIM);
    localparam int BXW  = cnt_w(WPR);
    localparam int BYW  = cnt_w(BPC);

    logic [RW-1:0]  r_row;
    logic [BXW-1:0] r_bx;
    logic [BYW-1:0] r_by;
    logic           w_row_end;
    logic           w_bx_end;
    logic           w_by_end;

    assign w_row_end = (r_row == RW'(DIM - 1));
    assign w_bx_end  = (r_bx  == BXW'(WPR - 1));
    assign w_by_end  = (r_by  == BYW'(BPC - 1));
    assign o_last    = w_row_end && w_bx_end && w_by_end;

    // Every operand is widened to ADDR first so no partial product is truncated.
    assign o_addr = (ADDR'(r_by) * ADDR'(DIM) + ADDR'(r_row)) * ADDR'(WPR) + ADDR'(r_bx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_bx  <= '0;
            r_by  <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_bx  <= '0;
            r_by  <= '0;
        end else if (i_adv) begin
            if (!w_row_end) begin
                r_row <= r_row + RW'(1);
            end else begin
                r_row <= '0;
                if (!w_bx_end) begin
                    r_bx <= r_bx + BXW'(1);
                end else begin
                    r_bx <= '0;
                    r_by <= w_by_end ? '0 : r_by + BYW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/segmentation_reassembler.sv
// Writes a row-per-beat stream of DIMxDIM blocks back to raster order in word memory.
// Optional REASM_CHECKSUM_EN: running pixel sum of the current frame.
module segmentation_reassembler
    import segmentation_pkg::*;
#(
    parameter int DIM   = DEF_DIM,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    segmentation_reassembler_if.slave  bus
);
    localparam int WPR   = IMG_W / DIM;
    localparam int DEPTH = WPR * IMG_H;
    localparam int ADDR  = $clog2(DEPTH);

    reasm_state_t     r_state;
    reasm_state_t     w_state_nxt;
    logic             w_busy;
    logic             w_accept;
    logic             w_last;
    logic [ADDR-1:0]  w_addr;

    logic             r_mem_we;
    logic [ADDR-1:0]  r_mem_addr;
    logic [WIDTH-1:0] r_mem_din [DIM];
    logic             r_frame_done;
    logic             r_overrun;

    reassembler_addr_gen #(
        .DIM   (DIM),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (!bus.enable),
        .i_adv  (w_accept),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping enable overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = RUN;
                RUN:     if (w_accept && w_last) w_state_nxt = DONE;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy   = (r_state == RUN);
        w_accept = w_busy && bus.enable && bus.valid_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '{default: '0};
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_mem_we     <= w_accept;
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                r_mem_addr <= w_addr;
                r_mem_din  <= bus.din;
            end
            if (!bus.enable) begin
                r_overrun <= 1'b0;
            end else if (r_state == DONE && bus.valid_in) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.busy       = w_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.overrun    = r_overrun;

`ifdef REASM_CHECKSUM_EN
    localparam int CKS_W = WIDTH + ADDR + $clog2(DIM);

    logic [CKS_W-1:0] w_beat_sum;
    logic [CKS_W-1:0] r_checksum;

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < DIM; i++) begin
            w_beat_sum = w_beat_sum + CKS_W'(bus.din[i]);
        end
    end

    // Cleared while idle, frozen in DONE because no beat is accepted there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_checksum <= '0;
        end else if (!bus.enable || r_state == IDLE) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + w_beat_sum;
        end
    end

    assign bus.checksum = r_checksum;
`else
`endif

endmodule

// File: doc/segmentation_reassembler.md
Name: segmentation_reassembler

Overview:
- Inverse of the image segmentation path: consumes the row-per-beat stream of DIM x DIM pixel blocks (one DIM-pixel row per valid beat) and writes each row back to its raster position in an image buffer.
- Sits between the compressor/decompressor output and a word-organised image memory, where one word holds DIM pixels.
- Generates the memory write port, a frame-complete pulse and an overrun flag.

Parameters:
- DIM, 8, block edge in pixels and pixels per beat/memory word
- WIDTH, 8, bits per pixel
- IMG_W, 256, image width in pixels; must be a multiple of DIM
- IMG_H, 256, image height in pixels; must be a multiple of DIM
- WPR, IMG_W/DIM, words per image row (localparam)
- DEPTH, WPR*IMG_H (8192), memory words (localparam)
- ADDR, $clog2(DEPTH), address width (localparam)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- enable  in  1  frame enable; level-sensitive
- valid_in  in  1  din carries one block row this cycle
- din  in  WIDTH x [DIM]  unpacked array, pixel 0 = leftmost
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR  word address
- mem_din  out  WIDTH x [DIM]  write data
- busy  out  1  state == RUN
- frame_done  out  1  one-cycle pulse after the last write of a frame
- overrun  out  1  sticky: valid_in seen in DONE state

Behaviour:
- Reset values: all outputs 0, mem_din all zero, state IDLE, all counters 0.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when enable=1. A valid_in in the same cycle is not accepted.
  - RUN -> DONE on the accepted beat where row=DIM-1, bx=WPR-1 and by=IMG_H/DIM-1.
  - any state -> IDLE when enable=0. This has priority over every other event. Counters clear. overrun clears. A write already registered still completes next cycle. frame_done is not raised for an aborted frame.
- Counters, advanced only on beats accepted in RUN:
  - row: 0..DIM-1, wraps to 0 and increments bx.
  - bx: 0..WPR-1, wraps to 0 and increments by.
  - by: 0..IMG_H/DIM-1.
- Address: mem_addr = (by*DIM + row)*WPR + bx, computed at full ADDR width with no truncation before the final result.
- Latency: the write is registered. The accepted beat at cycle N gives mem_we=1 with mem_addr/mem_din at cycle N+1. Back-to-back beats give back-to-back writes.
- mem_din holds its last value when mem_we=0.
- frame_done asserts in the same cycle as the final write's mem_we.
- DONE state:
  - valid_in is ignored and produces no write.
  - Any valid_in sets overrun, which holds until enable=0 or reset.
  - The block stays in DONE until enable drops; a new frame needs an enable low-to-high sequence.
- valid_in while enable=0: ignored, no write, no flag.
- Gaps in valid_in are allowed; counters hold across gaps.
- Reset mid-frame: all state and outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: REASM_CHECKSUM_EN.
- When defined:
  - Adds output checksum [WIDTH+ADDR+$clog2(DIM)-1:0].
  - It is the unsigned sum of every pixel of every accepted beat in the current frame.
  - It updates together with the write (N+1), clears on IDLE entry, and holds in DONE.
- When undefined: the port, adder and register are absent. All other behaviour is identical.

Decomposition:
- Package segmentation_pkg holds:
  - typedef pixel_t (logic [WIDTH-1:0]) and the row array type pixel_t [DIM]
  - enum reasm_state_t {IDLE, RUN, DONE}
  - default DIM/WIDTH constants, shared with the segmentation side
- One sub-module, reassembler_addr_gen, holds the row/bx/by counters and the address multiply-add. The top keeps the FSM, output registers, flags and the optional checksum.

Test Plan:
- Full frame, DIM=8, IMG_W=16, IMG_H=16, continuous valid_in with din row value = beat index -> 32 writes. Beat 0 writes addr 0, beat 8 writes addr 1, beat 16 writes addr 16, beat 31 writes addr 31. frame_done pulses at beat 31's write. busy drops after it.
- Gapped stream, valid_in toggled 1/0 over the same frame -> same address sequence. mem_we only on the cycle after each valid beat.
- Extra beat after frame end -> no mem_we, overrun=1. enable=0 clears overrun, state returns to IDLE.
- enable dropped after 10 beats, then re-raised -> no frame_done. The next accepted beat writes addr 0.
- rst asserted mid-frame with mem_we high -> all outputs 0 immediately. After release, first beat writes addr 0.
- REASM_CHECKSUM_EN defined, all pixels = 8'hFF, 16x16 frame -> checksum = 256*255 = 65280 at frame_done.
